// File: rtl/serpent_lt_keymix.sv
// Serpent round tail: linear transform plus round-key mix (encrypt) or key mix plus inverse LT (decrypt).
// The result is registered behind a valid/ready output stage with a one-entry skid buffer.
module serpent_lt_keymix #(
  parameter int TAG_W = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [127:0]       i_data,
  input  logic [127:0]       i_key,
  input  logic               i_decrypt,
  input  logic               i_last,
  input  logic [TAG_W-1:0]   i_tag,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [127:0]       o_data,
  output logic [TAG_W-1:0]   o_tag,
  output logic               o_valid,
  input  logic               i_ready
);

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic [127:0] lt_fwd(input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    x0 = d[31:0];
    x1 = d[63:32];
    x2 = d[95:64];
    x3 = d[127:96];
    x0 = rotl32(x0, 5'd13);
    x2 = rotl32(x2, 5'd3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rotl32(x1, 5'd1);
    x3 = rotl32(x3, 5'd7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rotl32(x0, 5'd5);
    x2 = rotl32(x2, 5'd22);
    return {x3, x2, x1, x0};
  endfunction

  // Undo each forward step in reverse order; the XOR steps are self-inverse.
  function automatic logic [127:0] lt_inv(input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    x0 = d[31:0];
    x1 = d[63:32];
    x2 = d[95:64];
    x3 = d[127:96];
    x2 = rotr32(x2, 5'd22);
    x0 = rotr32(x0, 5'd5);
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = x0 ^ x1 ^ x3;
    x3 = rotr32(x3, 5'd7);
    x1 = rotr32(x1, 5'd1);
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = x1 ^ x0 ^ x2;
    x2 = rotr32(x2, 5'd3);
    x0 = rotr32(x0, 5'd13);
    return {x3, x2, x1, x0};
  endfunction

  logic [127:0]     result;
  logic             accept;

  logic [127:0]     data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             valid_q, valid_d;
  logic [127:0]     skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_vld_q, skid_vld_d;
  logic             rdy_q, rdy_d;

  always_comb begin
    if (i_last) begin
      result = i_data ^ i_key;
    end else if (i_decrypt) begin
      result = lt_inv(i_data ^ i_key);
    end else begin
      result = lt_fwd(i_data) ^ i_key;
    end
  end

  assign accept = i_valid && rdy_q;

  // Output register refills from the skid first; the skid only fills while the output is stalled.
  always_comb begin
    data_d      = data_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    skid_vld_d  = skid_vld_q;
    if (!valid_q || i_ready) begin
      if (skid_vld_q) begin
        data_d     = skid_data_q;
        tag_d      = skid_tag_q;
        valid_d    = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        data_d  = result;
        tag_d   = i_tag;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d = result;
      skid_tag_d  = i_tag;
      skid_vld_d  = 1'b1;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q     <= '0;
      tag_q      <= '0;
      valid_q    <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      data_q     <= data_d;
      tag_q      <= tag_d;
      valid_q    <= valid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    skid_data_q <= skid_data_d;
    skid_tag_q  <= skid_tag_d;
  end

  assign o_data  = data_q;
  assign o_tag   = tag_q;
  assign o_valid = valid_q;
  assign o_ready = rdy_q;

endmodule

// File: doc/serpent_lt_keymix.md
Name: serpent_lt_keymix

Overview:
- Round-datapath stage sitting directly downstream of the Serpent S-box layer in the serpent_xts core.
- Encrypt mode: takes the 128-bit S-box output, applies the Serpent linear transformation (LT) and XORs the next round key.
- Decrypt mode: XORs the round key, then applies the inverse LT, ready for the inverse S-box layer.
- Registered output with valid/ready handshake and a one-entry skid buffer, so the round pipeline runs at full throughput under backpressure.

Parameters:
- TAG_W, 6, width of the sideband tag (round index/block id) carried alongside the data unchanged.

Ports:
- i_clk  in  1  clock; one clock domain.
- i_rst  in  1  reset; synchronous, active-high.
- i_data  in  128  {w3,w2,w1,w0}; w0 = bits [31:0] (same packing as the S-box layer output).
- i_key  in  128  round key, same word packing.
- i_decrypt  in  1  0 = forward LT path, 1 = inverse path.
- i_last  in  1  final round: LT/InvLT bypassed, output = i_data ^ i_key.
- i_tag  in  TAG_W  sideband, passed through.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  stage can accept a beat.
- o_data  out  128  result.
- o_tag  out  TAG_W  tag of o_data.
- o_valid  out  1  o_data valid.
- i_ready  in  1  downstream accepts.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: o_valid=0, o_ready=1, o_data=0, o_tag=0. The skid entry is emptied.
- Reset mid-operation drops both held beats. No partial output may appear.
- Function, evaluated combinationally on i_* at accept:
  - i_last=1: i_data^i_key.
  - enc: LT(i_data)^i_key.
  - dec: InvLT(i_data^i_key).
- LT, with X0..X3 = w0..w3, <<< = rotate, << = shift with zero fill:
  - X0<<<=13; X2<<<=3
  - X1=X1^X0^X2; X3=X3^X2^(X0<<3)
  - X1<<<=1; X3<<<=7
  - X0=X0^X1^X3; X2=X2^X3^(X1<<7)
  - X0<<<=5; X2<<<=22
- InvLT is the exact reverse:
  - X2>>>=22; X0>>>=5
  - X2=X2^X3^(X1<<7); X0=X0^X1^X3
  - X3>>>=7; X1>>>=1
  - X3=X3^X2^(X0<<3); X1=X1^X0^X2
  - X2>>>=3; X0>>>=13
- All arithmetic is 32-bit modulo.
- Handshake:
  - A beat is accepted when i_valid&&o_ready.
  - Output transfers when o_valid&&i_ready.
  - Latency is 1 cycle: the accepted beat appears on o_data/o_valid on the next edge when the output register is empty or draining.
- Skid buffer and storage:
  - Output register plus one skid entry; o_ready is a registered signal = skid empty.
  - Accept while output is full and i_ready=0: the beat goes to the skid entry and o_ready drops next cycle.
  - When the output transfers and the skid is full: the skid moves into the output register and o_ready rises next cycle.
- Simultaneous accept and transfer with the skid empty: the output register loads the new beat and o_valid stays 1 (no bubble).
- o_data/o_tag are held stable while o_valid=1 and i_ready=0.
- i_valid is ignored while o_ready=0; no beat is lost or duplicated.
- Throughput: 1 beat/cycle sustained when i_ready=1.

Test Plan:
- Forward LT: i_data w0=0x00000001, others 0, key 0, enc, i_last=0 -> one cycle later o_valid=1, w3..w0 = 0x00800000, 0x00002800, 0x00004000, 0x100C0000.
- Inverse LT: feed that output with dec=1, key 0 -> o_data w0=0x00000001, others 0. Repeat for 1000 random vectors: InvLT(LT(x)) == x.
- Last-round bypass: i_last=1, data=0xFFFF...FF, key=0x0123456789ABCDEF0011223344556677 -> o_data = bitwise complement of key, for both enc and dec.
- Backpressure:
  - Stream 8 beats (tags 0..7) with i_valid=1 continuously while i_ready is toggled 1,0,0,1,... randomly.
  - Required: tags exit in order 0..7 exactly once.
  - Required: o_ready=0 only while the skid is full.
  - Required: o_data stable while stalled.
- Full throughput: i_ready=1 with 16 back-to-back beats -> o_valid high for 16 consecutive cycles starting 1 cycle after the first accept.
- Reset mid-stream: fill the output and skid (i_ready=0), assert i_rst 1 cycle -> next cycle o_valid=0, o_ready=1, o_data=0; the subsequent beat passes with 1-cycle latency.
